// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Parity over up to 9 data bits; narrower words are zero-extended by the caller.
    function automatic logic calc_parity(input logic [8:0] data, input logic typ);
        return (typ == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period down-counter: bit_tick marks the last clock of each bit period.
module uart_baud_cnt #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  bit_tick
);

    logic [PRESCALE_W-1:0] period_q;
    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] load_val;

    // A prescale of zero behaves as one clock per bit.
    always_comb begin
        load_val = '0;
        if (prescale != '0) begin
            load_val = prescale - PRESCALE_W'(1);
        end
    end

    // Restart on frame load, otherwise count down and reload on expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            period_q <= load_val;
            cnt_q    <= load_val;
        end else if (cnt_q == '0) begin
            cnt_q    <= period_q;
        end else begin
            cnt_q    <= cnt_q - PRESCALE_W'(1);
        end
    end

    // Tick on the final clock of the current bit period.
    always_comb begin
        bit_tick = (cnt_q == '0);
    end

endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART transmitter: holding register, frame FSM and registered serial output.
module uart_tx_frame_gen
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic                  party_en,
    input  logic                  party_typ,
    input  logic                  stop2,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  Tx_OUT,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    // Holding register (one word plus its per-frame configuration)
    logic                  hold_full_q;
    logic [DATA_WIDTH-1:0] hold_data_q;
    logic                  hold_pe_q;
    logic                  hold_pt_q;
    logic                  hold_s2_q;
    logic [PRESCALE_W-1:0] hold_ps_q;

    // Active frame state
    tx_state_t             state_q, state_nxt;
    logic [DATA_WIDTH-1:0] shift_q, shift_nxt;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_nxt;
    logic                  stop_idx_q, stop_idx_nxt;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  stop2_q;
    logic                  tx_q, tx_nxt;
    logic                  done_q, done_nxt;

    logic accept;
    logic load;
    logic bit_tick;

    always_comb begin
        accept     = data_valid && !hold_full_q;
        data_ready = !hold_full_q;
        busy       = (state_q != ST_IDLE);
        Tx_OUT     = tx_q;
        frame_done = done_q;
    end

    uart_baud_cnt #(
        .PRESCALE_W(PRESCALE_W)
    ) u_baud (
        .clk      (CLK),
        .rst_n    (RST),
        .load     (load),
        .prescale (hold_ps_q),
        .bit_tick (bit_tick)
    );

    // Holding register: fill on handshake, free when the FSM takes the word.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            hold_pe_q   <= 1'b0;
            hold_pt_q   <= 1'b0;
            hold_s2_q   <= 1'b0;
            hold_ps_q   <= '0;
        end else if (accept) begin
            hold_full_q <= 1'b1;
            hold_data_q <= P_DATA;
            hold_pe_q   <= party_en;
            hold_pt_q   <= party_typ;
            hold_s2_q   <= stop2;
            hold_ps_q   <= prescale;
        end else if (load) begin
            hold_full_q <= 1'b0;
        end
    end

    // Frame state registers; configuration is frozen at load time.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            shift_q    <= shift_nxt;
            bit_idx_q  <= bit_idx_nxt;
            stop_idx_q <= stop_idx_nxt;
            tx_q       <= tx_nxt;
            done_q     <= done_nxt;
            if (load) begin
                par_en_q  <= hold_pe_q;
                par_bit_q <= calc_parity(9'(hold_data_q), hold_pt_q);
                stop2_q   <= hold_s2_q;
            end
        end
    end

    // Next-state logic; the line level is derived from the next state so Tx_OUT stays a flop.
    always_comb begin
        state_nxt    = state_q;
        shift_nxt    = shift_q;
        bit_idx_nxt  = bit_idx_q;
        stop_idx_nxt = stop_idx_q;
        load         = 1'b0;
        done_nxt     = 1'b0;
        tx_nxt       = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    state_nxt = ST_START;
                    load      = 1'b1;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        state_nxt = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx_q + IDX_W'(1);
                        shift_nxt   = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (stop2_q && !stop_idx_q) begin
                        stop_idx_nxt = 1'b1;
                    end else begin
                        done_nxt = 1'b1;
                        if (hold_full_q) begin
                            state_nxt = ST_START;
                            load      = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (load) begin
            shift_nxt    = hold_data_q;
            bit_idx_nxt  = '0;
            stop_idx_nxt = 1'b0;
        end

        unique case (state_nxt)
            ST_START:  tx_nxt = 1'b0;
            ST_DATA:   tx_nxt = shift_nxt[0];
            ST_PARITY: tx_nxt = par_bit_q;
            default:   tx_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Scoreboard bench for uart_tx_frame_gen: driver pushes expected frames, monitor checks the line.
module tb_uart_tx_frame_gen;

    localparam int W  = 8;
    localparam int PW = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [W-1:0]  P_DATA = '0;
    logic          data_valid = 1'b0;
    logic          party_en = 1'b0;
    logic          party_typ = 1'b0;
    logic          stop2 = 1'b0;
    logic [PW-1:0] prescale = '0;
    logic          data_ready;
    logic          Tx_OUT;
    logic          busy;
    logic          frame_done;

    typedef struct {
        logic [W-1:0] d;
        bit           pe;
        bit           pt;
        bit           s2;
        int           p;
        int           acc;
    } rec_t;

    rec_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_end = 0;
    bit   mon_busy = 1'b0;
    int   last_acc = 0;

    uart_tx_frame_gen #(
        .DATA_WIDTH(W),
        .PRESCALE_W(PW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .party_en   (party_en),
        .party_typ  (party_typ),
        .stop2      (stop2),
        .prescale   (prescale),
        .Tx_OUT     (Tx_OUT),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with valid still high.
    task automatic send(input logic [W-1:0] d, input bit pe, input bit pt, input bit s2, input int ps);
        rec_t r;
        int   n;
        P_DATA     = d;
        party_en   = pe;
        party_typ  = pt;
        stop2      = s2;
        prescale   = PW'(ps);
        data_valid = 1'b1;
        n = 0;
        while (!data_ready && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        if (!data_ready) begin
            check("accept_timeout", n, 0);
        end else begin
            r.d = d; r.pe = pe; r.pt = pt; r.s2 = s2;
            r.p = (ps == 0) ? 1 : ps;
            r.acc = cyc + 1;
            last_acc = r.acc;
            q.push_back(r);
            @(negedge CLK);
        end
    endtask

    task automatic idle(input int n);
        data_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            P_DATA = W'($urandom);
            @(negedge CLK);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || mon_busy || busy) && n < 30000) begin
            @(negedge CLK);
            n++;
        end
        check("drain_done", (n < 30000) ? 1 : 0, 1);
        @(negedge CLK);
    endtask

    // Monitor: detects each start bit and compares the whole frame against the popped record.
    initial begin : monitor
        bit    reuse;
        rec_t  r;
        int    lvl[$];
        int    bad;
        bit    ab;
        int    exp_start;
        int    par;
        reuse = 1'b0;
        forever begin
            if (!reuse) @(negedge CLK);
            reuse = 1'b0;
            if (!RST) begin
                q.delete();
                last_end = 0;
                continue;
            end
            if (Tx_OUT === 1'b0) begin
                mon_busy = 1'b1;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame actual=start_bit required=idle_line cyc=%0d", cyc);
                    mon_busy = 1'b0;
                    continue;
                end
                r = q.pop_front();
                exp_start = (r.acc + 1 > last_end) ? r.acc + 1 : last_end;
                check($sformatf("start_edge_%02h", r.d), cyc, exp_start);
                lvl.delete();
                par = ($countones(r.d) % 2) ^ int'(r.pt);
                for (int k = 0; k < r.p; k++) lvl.push_back(0);
                for (int b = 0; b < W; b++)
                    for (int k = 0; k < r.p; k++) lvl.push_back(int'(r.d[b]));
                if (r.pe)
                    for (int k = 0; k < r.p; k++) lvl.push_back(par);
                for (int k = 0; k < (r.s2 ? 2 : 1) * r.p; k++) lvl.push_back(1);
                bad = 0;
                ab = 1'b0;
                for (int i = 0; i < lvl.size(); i++) begin
                    if (i > 0) begin
                        @(negedge CLK);
                        if (!RST) begin ab = 1'b1; break; end
                    end
                    if (Tx_OUT !== 1'(lvl[i]) || busy !== 1'b1 || (i > 0 && frame_done !== 1'b0))
                        bad++;
                end
                if (!ab) begin
                    check($sformatf("frame_bits_%02h_len%0d", r.d, lvl.size()), bad, 0);
                    @(negedge CLK);
                    if (!RST) ab = 1'b1;
                end
                if (ab) begin
                    q.delete();
                    last_end = 0;
                    mon_busy = 1'b0;
                    continue;
                end
                check("frame_done_pulse", int'(frame_done), 1);
                last_end = cyc;
                check("busy_after_frame", int'(busy), (q.size() > 0 && q[0].acc < cyc) ? 1 : 0);
                mon_busy = 1'b0;
                reuse = 1'b1;
            end
        end
    end

    initial begin : stim
        int a;
        int n;
        #1 RST = 1'b0;
        #1;
        check("reset_tx", int'(Tx_OUT), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_ready", int'(data_ready), 1);
        check("reset_done", int'(frame_done), 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        send(8'hA5, 1'b0, 1'b0, 1'b0, 4); idle(5);
        drain();
        send(8'h17, 1'b1, 1'b0, 1'b0, 4); idle(3);
        send(8'h17, 1'b1, 1'b1, 1'b0, 4); idle(3);
        send(8'hFF, 1'b0, 1'b0, 1'b1, 2); idle(3);
        send(8'hFF, 1'b0, 1'b0, 1'b0, 0); idle(3);
        drain();
        send(8'h33, 1'b0, 1'b0, 1'b0, 3);
        send(8'hCC, 1'b0, 1'b0, 1'b0, 3);
        idle(0);
        check("b2b_holding_busy", int'(data_ready), 0);
        drain();

        for (int i = 0; i < 40; i++) begin
            send(W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 6)));
            idle(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0);
        end
        drain();

        send(8'h3C, 1'b0, 1'b0, 1'b0, 4);
        idle(0);
        a = last_acc;
        n = 0;
        while (cyc < a + 18 && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        check("reach_data_bit3", (cyc >= a + 18) ? 1 : 0, 1);
        #2 RST = 1'b0;
        #1;
        check("midreset_tx", int'(Tx_OUT), 1);
        check("midreset_busy", int'(busy), 0);
        check("midreset_ready", int'(data_ready), 1);
        check("midreset_done", int'(frame_done), 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        send(8'h5A, 1'b0, 1'b0, 1'b0, 4); idle(2);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
